uart_tx_arbiter: RTL and testbench

Shares one uart_tx serializer between N_REQ byte producers. Round-robin arbitration selects one requester per frame over a valid/ready handshake. The block drives the serializer's tx_start/tx_data. It tracks frame occupancy by counting baud ticks, because the serializer exposes no busy flag. It sits between producers (command/debug/log sources) and uart_tx, and shares clk/baud_tick with it.

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-arbiter state encoding and default frame geometry.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_FRAME_TICKS = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } uart_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first active request found
// searching upward from ptr+1 with wrap-around.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx
);

    logic found;
    int   pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = (int'(ptr) + k) % N_REQ;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx serializer between N_REQ byte producers.
// Define UART_TX_ARBITER_STATS_EN to add the frame_done / frame_cnt outputs.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int FRAME_TICKS = UART_FRAME_TICKS,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         baud_tick,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*UART_DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         tx_start,
    output logic [UART_DATA_W-1:0]       tx_data,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy
`ifdef UART_TX_ARBITER_STATS_EN
    ,
    output logic                         frame_done,
    output logic [15:0]                  frame_cnt
`endif
);

    localparam int CNT_W = $clog2(FRAME_TICKS + 1);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_LAUNCH = LAUNCH;
    localparam logic [1:0] ST_WAIT   = WAIT;

    logic [1:0]       state;
    logic [CNT_W-1:0] tick_cnt;
    logic [ID_W-1:0]  rr_ptr;
    logic [N_REQ-1:0] pick_grant;
    logic [ID_W-1:0]  pick_idx;
    logic             accept;
    logic             frame_end;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .grant(pick_grant),
        .idx  (pick_idx)
    );

    assign req_ready = (state == ST_IDLE) ? pick_grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign frame_end = (state == ST_WAIT) && baud_tick && (tick_cnt == CNT_W'(FRAME_TICKS - 1));

    // The serializer ignores the tick in its load cycle, so counting starts only in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            tick_cnt <= '0;
            rr_ptr   <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx_data  <= req_data[int'(pick_idx)*UART_DATA_W +: UART_DATA_W];
                        grant_id <= pick_idx;
                        rr_ptr   <= pick_idx;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    tx_start <= 1'b0;
                    tick_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (baud_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                    if (frame_end) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_ARBITER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter against a frame-level reference model.
module tb_uart_tx_arbiter;

    localparam int N_REQ       = 4;
    localparam int FRAME_TICKS = 10;

    logic               clk;
    logic               rst;
    logic               baud_tick;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*8-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic [1:0]         grant_id;
    logic               busy;
`ifdef UART_TX_ARBITER_STATS_EN
    logic               frame_done;
    logic [15:0]        frame_cnt;
`endif

    uart_tx_arbiter #(
        .N_REQ      (N_REQ),
        .FRAME_TICKS(FRAME_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef UART_TX_ARBITER_STATS_EN
        ,
        .frame_done(frame_done),
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         errors;
    int         checks;

    // Reference model: producers' pending bytes plus frame occupancy in ticks.
    bit         m_free;
    bit         m_launch;
    int         m_left;
    int         m_ptr;
    int         m_frames;
    bit         m_frame_edge;
    bit         dec_accept;
    int         dec_w;
    bit         tick_prev;
    bit         pend[N_REQ];
    logic [7:0] pdata[N_REQ];
    logic [7:0] last_data;
    int         tick_pct;
    bit         all_valid;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        int         w;
        logic [N_REQ-1:0] exp_ready;
        @(negedge clk);
        m_frame_edge = 1'b0;
        if (m_free) begin
            if (dec_accept) begin
                m_free      = 1'b0;
                m_launch    = 1'b1;
                m_ptr       = dec_w;
                pend[dec_w] = 1'b0;
            end
        end else if (m_launch) begin
            m_launch = 1'b0;
            m_left   = FRAME_TICKS;
        end else if (tick_prev) begin
            m_left--;
            if (m_left == 0) begin
                m_free       = 1'b1;
                m_frames++;
                m_frame_edge = 1'b1;
            end
        end
        dec_accept = 1'b0;

        checkOutput("busy", busy, !m_free);
        checkOutput("tx_start", tx_start, m_launch);
`ifdef UART_TX_ARBITER_STATS_EN
        checkOutput("frame_done", frame_done, m_frame_edge);
        checkOutput("frame_cnt", frame_cnt, 32'(m_frames & 32'hFFFF));
`endif

        baud_tick = ($urandom_range(0, 99) < tick_pct);
        for (int i = 0; i < N_REQ; i++) begin
            if (all_valid) begin
                if (!pend[i]) begin
                    pend[i]  = 1'b1;
                    pdata[i] = 8'(16 + i);
                end
            end else if (pend[i] && !m_free && $urandom_range(0, 7) == 0) begin
                pend[i] = 1'b0;
            end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                pend[i]  = 1'b1;
                pdata[i] = 8'($urandom);
            end
            req_valid[i]       = pend[i];
            req_data[i*8 +: 8] = pdata[i];
        end

        #1;
        w         = -1;
        exp_ready = '0;
        if (m_free) begin
            for (int k = 1; k <= N_REQ; k++) begin
                if (w < 0 && pend[(m_ptr + k) % N_REQ]) begin
                    w = (m_ptr + k) % N_REQ;
                end
            end
        end
        if (w >= 0) begin
            exp_ready[w] = 1'b1;
            dec_accept   = 1'b1;
            dec_w        = w;
            sb.push_back('{w, pdata[w]});
        end
        checkOutput("req_ready", req_ready, exp_ready);
        tick_prev = baud_tick;
    endtask

    // Monitor: every launch must match the oldest predicted grant; otherwise tx_data holds.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (tx_start) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_launch: got tx_data %0h expected no launch", tx_data);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("tx_data", tx_data, e.data);
                        checkOutput("grant_id", grant_id, e.id);
                        last_data = e.data;
                    end
                end else begin
                    checkOutput("tx_hold", tx_data, last_data);
                end
            end
        end
    end

    initial begin
        int guard;
        clk        = 1'b0;
        rst        = 1'b1;
        baud_tick  = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        errors     = 0;
        checks     = 0;
        m_free     = 1'b1;
        m_launch   = 1'b0;
        m_left     = 0;
        m_ptr      = N_REQ - 1;
        m_frames   = 0;
        dec_accept = 1'b0;
        tick_prev  = 1'b0;
        last_data  = '0;
        tick_pct   = 30;
        all_valid  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = '0;
        end

        #2;
        checkOutput("rst_tx_start", tx_start, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_grant_id", grant_id, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        repeat (600) applyStimulus();

        all_valid = 1'b1;
        tick_pct  = 100;
        repeat (200) applyStimulus();

        all_valid = 1'b0;
        tick_pct  = 40;
        guard     = 0;
        while (!(!m_free && !m_launch && m_left == FRAME_TICKS - 4) && guard < 2000) begin
            applyStimulus();
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("[TB] FAIL midframe_wait: got timeout expected WAIT with 4 ticks counted");
        end

        #1;
        rst       = 1'b1;
        req_valid = '0;
        #1;
        checkOutput("midrst_tx_start", tx_start, 0);
        checkOutput("midrst_tx_data", tx_data, 0);
        checkOutput("midrst_grant_id", grant_id, 0);
        checkOutput("midrst_busy", busy, 0);
`ifdef UART_TX_ARBITER_STATS_EN
        checkOutput("midrst_frame_cnt", frame_cnt, 0);
`endif
        m_free     = 1'b1;
        m_launch   = 1'b0;
        m_left     = 0;
        m_ptr      = N_REQ - 1;
        m_frames   = 0;
        dec_accept = 1'b0;
        tick_prev  = 1'b0;
        last_data  = '0;
        sb.delete();
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;

        repeat (400) applyStimulus();

        repeat (2) @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
